// File: rtl/add_issue_pkg.sv
// Shared types and default sizing for the adder operand issue stage.
package add_issue_pkg;

    localparam int ADD_ISSUE_WIDTH_DEFAULT = 4;
    localparam int ADD_ISSUE_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [ADD_ISSUE_WIDTH_DEFAULT-1:0] a;
        logic [ADD_ISSUE_WIDTH_DEFAULT-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/add_adder.sv
// Combinational adder; SUM_W selects whether the carry bit is produced.
module add_adder #(
    parameter int WIDTH = 4,
    parameter int SUM_W = WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [SUM_W-1:0] sum
);

    assign sum = SUM_W'(a) + SUM_W'(b);

endmodule

// File: rtl/add_operand_fifo.sv
// Operand-pair FIFO: storage, wrapping pointers and an occupancy counter
// that alone decides full/empty.
module add_operand_fifo
    import add_issue_pkg::*;
#(
    parameter int WIDTH = ADD_ISSUE_WIDTH_DEFAULT,
    parameter int DEPTH = ADD_ISSUE_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [2*WIDTH-1:0]           wr_data,
    output logic [2*WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/add_issue_stage.sv
// Operand issue stage: FIFO-buffered operand pairs feed an adder whose sum is
// registered behind a valid/ready output. Option: ADD_ISSUE_STAGE_CARRY_OUT_EN adds out_carry.
module add_issue_stage
    import add_issue_pkg::*;
#(
    parameter int WIDTH = ADD_ISSUE_WIDTH_DEFAULT,
    parameter int DEPTH = ADD_ISSUE_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_sum,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef ADD_ISSUE_STAGE_CARRY_OUT_EN
    ,
    output logic                         out_carry
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and ready here depends only
    // on registered occupancy.

`ifdef ADD_ISSUE_STAGE_CARRY_OUT_EN
    localparam int SUM_W = WIDTH + 1;
`else
    localparam int SUM_W = WIDTH;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    pair_t            wr_pair;
    pair_t            head_pair;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             load;
    logic [SUM_W-1:0] sum;

    assign wr_pair.a = in_a;
    assign wr_pair.b = in_b;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready && !flush;
    // Refill the output register when it is empty or being consumed this cycle.
    assign load     = (!out_valid || out_ready) && !fifo_empty && !flush;

    add_operand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .pop     (load),
        .wr_data (wr_pair),
        .rd_data (head_pair),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    add_adder #(
        .WIDTH (WIDTH),
        .SUM_W (SUM_W)
    ) u_adder (
        .a   (head_pair.a),
        .b   (head_pair.b),
        .sum (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sum   <= sum[WIDTH-1:0];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ADD_ISSUE_STAGE_CARRY_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_carry <= 1'b0;
        end else if (load) begin
            out_carry <= sum[WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_add_issue_stage.sv
// Self-checking bench for add_issue_stage: a negedge monitor scores every
// output transfer against an expected queue filled on each accepted input.
module tb_add_issue_stage;
    import add_issue_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CW-1:0]    count;
`ifdef ADD_ISSUE_STAGE_CARRY_OUT_EN
    logic             out_carry;
`endif

    logic [WIDTH:0] exp_q[$];
    int             checks;
    int             errors;
    int             pops;

    add_issue_stage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .count     (count)
`ifdef ADD_ISSUE_STAGE_CARRY_OUT_EN
        ,
        .out_carry (out_carry)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on output transfer, push on input acceptance.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    logic [WIDTH:0] e;
                    e = exp_q.pop_front();
                    pops++;
                    check("sb_sum", int'(out_sum), int'(e[WIDTH-1:0]));
`ifdef ADD_ISSUE_STAGE_CARRY_OUT_EN
                    check("sb_carry", int'(out_carry), int'(e[WIDTH]));
`endif
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
            end
        end
    end

    // Drivers
    task automatic drive_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            step();
            n++;
        end
        check("drain_done", int'(exp_q.size() == 0 && !out_valid), 1);
    endtask

    operand_pair_t wrap_tbl [2];

    initial begin
        int acc;
        int p0;
        checks    = 0;
        errors    = 0;
        pops      = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        wrap_tbl[0] = '{a: 4'd15, b: 4'd1};
        wrap_tbl[1] = '{a: 4'd3,  b: 4'd4};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_count", int'(count), 0);
        step();
        check("rst_in_ready", int'(in_ready), 1);

        // Single pair: result valid two edges after acceptance
        out_ready = 1'b1;
        drive_pair(4'd5, 4'd6);
        check("single_count_c1", int'(count), 1);
        check("single_valid_c1", int'(out_valid), 0);
        step();
        check("single_valid_c2", int'(out_valid), 1);
        check("single_sum_c2", int'(out_sum), 11);
        step();
        check("single_valid_c3", int'(out_valid), 0);

        // Wrap and carry
        foreach (wrap_tbl[i]) drive_pair(wrap_tbl[i].a, wrap_tbl[i].b);
        wait_drain();
        check("wrap_sum_hold", int'(out_sum), 7);
`ifdef ADD_ISSUE_STAGE_CARRY_OUT_EN
        check("wrap_carry_hold", int'(out_carry), 0);
`endif

        // Backpressure: exactly DEPTH+1 pairs fit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (in_ready) acc++;
            in_a = 4'($urandom_range(0, 15));
            in_b = 4'($urandom_range(0, 15));
            step();
        end
        in_valid = 1'b0;
        check("bp_accepted", acc, DEPTH + 1);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_count", int'(count), DEPTH);
        check("bp_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            check("bp_drain_valid", int'(out_valid), 1);
            step();
            if (i == 0) check("bp_ready_back", int'(in_ready), 1);
        end
        check("bp_drain_end", int'(out_valid), 0);

        // Streaming: 16 back-to-back pairs
        p0 = pops;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_a = 4'($urandom_range(0, 15));
            in_b = 4'($urandom_range(0, 15));
            step();
            check("stream_count_le1", int'(count <= 1), 1);
            check("stream_valid", int'(out_valid), int'(i >= 1));
        end
        in_valid = 1'b0;
        step();
        check("stream_last_valid", int'(out_valid), 1);
        step();
        check("stream_end_valid", int'(out_valid), 0);
        check("stream_results", pops - p0, 16);

        // Flush with count=3 and out_valid=1, concurrent push dropped
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive_pair(4'($urandom_range(0, 15)), 4'(i));
        check("pre_flush_count", int'(count), 3);
        check("pre_flush_valid", int'(out_valid), 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a     = 4'd2;
        in_b     = 4'd2;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", int'(count), 0);
        check("flush_valid", int'(out_valid), 0);
        out_ready = 1'b1;
        repeat (3) step();
        check("flush_no_ghost_valid", int'(out_valid), 0);
        check("flush_no_ghost_count", int'(count), 0);

        // Async reset between edges with count=2
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive_pair(4'd1, 4'(i));
        check("pre_rst_count", int'(count), 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_count", int'(count), 0);
        exp_q.delete();
        #3 rst = 1'b0;
        step();
        out_ready = 1'b1;
        drive_pair(4'd9, 4'd8);
        step();
        check("post_rst_valid", int'(out_valid), 1);
        check("post_rst_sum", int'(out_sum), 1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
